// File: rtl/rp_bus_arb.sv
// rp_bus_arb
// Shares one memory port between the instruction-fetch (program) bus and the
// load/store (data) bus. All three ports use the same req/ack handshake:
// a transfer completes in the cycle where req and ack are both high, and
// read data is valid in that ack cycle.
//
// Data normally wins over fetch. A starvation counter lets a waiting fetch
// through after MAXW consecutive data grants. Once a transfer is not
// acknowledged in its first cycle, the grant is locked to that requester
// until its ack arrives.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   prg_req/adr, prg_rdt/ack fetch bus (read only)
//   dat_req/wen/adr/sel/wdt  data bus request side
//   dat_rdt/ack              data bus response side
//   mem_req/wen/adr/sel/wdt  unified memory request side
//   mem_rdt/ack              unified memory response side
//   gnt                      current owner, one-hot: [0]=prg, [1]=dat
module rp_bus_arb #(
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int SW   = DW / 8,
    parameter int MAXW = 4,
    parameter int CW   = $clog2(MAXW + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prg_req,
    input  logic [AW-1:0] prg_adr,
    output logic [DW-1:0] prg_rdt,
    output logic          prg_ack,
    input  logic          dat_req,
    input  logic          dat_wen,
    input  logic [AW-1:0] dat_adr,
    input  logic [SW-1:0] dat_sel,
    input  logic [DW-1:0] dat_wdt,
    output logic [DW-1:0] dat_rdt,
    output logic          dat_ack,
    output logic          mem_req,
    output logic          mem_wen,
    output logic [AW-1:0] mem_adr,
    output logic [SW-1:0] mem_sel,
    output logic [DW-1:0] mem_wdt,
    input  logic [DW-1:0] mem_rdt,
    input  logic          mem_ack,
    output logic [1:0]    gnt
);

    // With MAXW=0 the derived width collapses to zero; keep at least one bit.
    localparam int              CNT_W   = (CW > 0) ? CW : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAXW);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PRG  = 2'd1;
    localparam logic [1:0] ST_DAT  = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             own_prg;
    logic             own_dat;
    logic             xfer;

    // Owner selection. In IDLE the winner is decided combinationally so the
    // memory sees the request in the same cycle; in a locked state the owner
    // is fixed regardless of the other requester. Reset forces no owner.
    always_comb begin
        own_prg = 1'b0;
        own_dat = 1'b0;
        if (!rst) begin
            case (state)
                ST_IDLE: begin
                    if (dat_req && (!prg_req || (cnt < CNT_MAX)))
                        own_dat = 1'b1;
                    else if (prg_req)
                        own_prg = 1'b1;
                end
                ST_PRG:  own_prg = 1'b1;
                ST_DAT:  own_dat = 1'b1;
                default: ;
            endcase
        end
    end

    // mem_req follows the owner's own req, so an owner dropping req while
    // locked produces no memory request and cannot be acknowledged.
    always_comb begin
        mem_req = 1'b0;
        mem_wen = 1'b0;
        mem_adr = '0;
        mem_sel = '0;
        mem_wdt = '0;
        if (own_prg) begin
            mem_req = prg_req;
            mem_adr = prg_adr;
            mem_sel = '1;
        end else if (own_dat) begin
            mem_req = dat_req;
            mem_wen = dat_wen;
            mem_adr = dat_adr;
            mem_sel = dat_sel;
            mem_wdt = dat_wdt;
        end
    end

    // A memory ack only counts while a request is actually presented.
    assign xfer    = mem_req & mem_ack;
    assign prg_ack = own_prg & xfer;
    assign dat_ack = own_dat & xfer;
    assign prg_rdt = mem_rdt;
    assign dat_rdt = mem_rdt;
    assign gnt     = {own_dat, own_prg};

    // Lock onto the winner only when its transfer did not finish in the
    // first cycle; release on ack or when the owner withdraws its request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_req && !mem_ack)
                        state <= own_dat ? ST_DAT : ST_PRG;
                end
                ST_PRG, ST_DAT: begin
                    if (!mem_req || mem_ack)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Count data transfers completed while a fetch is waiting; any other
    // completed transfer means the fetch side is not starving.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (xfer) begin
            if (own_dat && prg_req)
                cnt <= (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
            else
                cnt <= '0;
        end
    end

endmodule

// File: tb/tb_rp_bus_arb.sv
// tb_rp_bus_arb
// Self-checking bench for rp_bus_arb with MAXW=4. A behavioural model tracks
// which requester currently holds the port and how many data transfers in a
// row have completed while a fetch waited; a compare process checks every
// DUT output against it on each falling edge. Directed sequences add
// hand-computed literal checks on top.
module tb_rp_bus_arb;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SW   = 4;
    localparam int MAXW = 4;

    localparam int NONE = 0;
    localparam int PRG  = 1;
    localparam int DAT  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          prg_req;
    logic [AW-1:0] prg_adr;
    logic [DW-1:0] prg_rdt;
    logic          prg_ack;
    logic          dat_req;
    logic          dat_wen;
    logic [AW-1:0] dat_adr;
    logic [SW-1:0] dat_sel;
    logic [DW-1:0] dat_wdt;
    logic [DW-1:0] dat_rdt;
    logic          dat_ack;
    logic          mem_req;
    logic          mem_wen;
    logic [AW-1:0] mem_adr;
    logic [SW-1:0] mem_sel;
    logic [DW-1:0] mem_wdt;
    logic [DW-1:0] mem_rdt;
    logic          mem_ack;
    logic [1:0]    gnt;

    int tests = 0;
    int fails = 0;

    // Model state: who holds a locked grant, and the data streak length.
    int holder = NONE;
    int streak = 0;

    rp_bus_arb #(.AW(AW), .DW(DW), .SW(SW), .MAXW(MAXW)) dut (
        .clk(clk), .rst(rst),
        .prg_req(prg_req), .prg_adr(prg_adr), .prg_rdt(prg_rdt), .prg_ack(prg_ack),
        .dat_req(dat_req), .dat_wen(dat_wen), .dat_adr(dat_adr), .dat_sel(dat_sel),
        .dat_wdt(dat_wdt), .dat_rdt(dat_rdt), .dat_ack(dat_ack),
        .mem_req(mem_req), .mem_wen(mem_wen), .mem_adr(mem_adr), .mem_sel(mem_sel),
        .mem_wdt(mem_wdt), .mem_rdt(mem_rdt), .mem_ack(mem_ack), .gnt(gnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic pr, input logic [31:0] pa, input logic dr,
                                 input logic dw, input logic [31:0] da, input logic [3:0] ds,
                                 input logic [31:0] dwd, input logic ma, input logic [31:0] mr);
        prg_req = pr;
        prg_adr = pa;
        dat_req = dr;
        dat_wen = dw;
        dat_adr = da;
        dat_sel = ds;
        dat_wdt = dwd;
        mem_ack = ma;
        mem_rdt = mr;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic int whoNow();
        if (rst) return NONE;
        if (holder != NONE) return holder;
        if (prg_req && dat_req) return (streak < MAXW) ? DAT : PRG;
        if (dat_req) return DAT;
        if (prg_req) return PRG;
        return NONE;
    endfunction

    function automatic logic reqOf(input int who);
        if (who == PRG) return prg_req;
        if (who == DAT) return dat_req;
        return 1'b0;
    endfunction

    // Model advance: a finished transfer frees the port and updates the
    // streak; an unfinished one keeps the requester as holder.
    always @(posedge clk) begin
        int  who;
        logic done;
        if (rst) begin
            holder = NONE;
            streak = 0;
        end else begin
            who  = whoNow();
            done = reqOf(who) && mem_ack;
            if (done) begin
                holder = NONE;
                if (who == DAT && prg_req)
                    streak = (streak + 1 > MAXW) ? MAXW : streak + 1;
                else
                    streak = 0;
            end else if (who != NONE && reqOf(who)) begin
                holder = who;
            end else begin
                holder = NONE;
            end
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        int   who;
        logic req;
        who = whoNow();
        req = reqOf(who);
        checkOutput("m_mem_req", 32'(mem_req), 32'(req));
        checkOutput("m_mem_wen", 32'(mem_wen), 32'((who == DAT) ? dat_wen : 1'b0));
        checkOutput("m_mem_adr", mem_adr, (who == DAT) ? dat_adr : (who == PRG) ? prg_adr : 32'h0);
        checkOutput("m_mem_sel", 32'(mem_sel), 32'((who == DAT) ? dat_sel : (who == PRG) ? 4'hF : 4'h0));
        checkOutput("m_mem_wdt", mem_wdt, (who == DAT) ? dat_wdt : 32'h0);
        checkOutput("m_prg_ack", 32'(prg_ack), 32'(who == PRG && req && mem_ack));
        checkOutput("m_dat_ack", 32'(dat_ack), 32'(who == DAT && req && mem_ack));
        checkOutput("m_gnt", 32'(gnt), (who == DAT) ? 32'd2 : (who == PRG) ? 32'd1 : 32'd0);
        checkOutput("m_prg_rdt", prg_rdt, mem_rdt);
        checkOutput("m_dat_rdt", dat_rdt, mem_rdt);
    end

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("rst_gnt", 32'(gnt), 32'd0);
        checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
        nextCycle();
        rst = 1'b0;

        // Fetch only, single-cycle acks, no bubbles.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 32'(4 * i), 0, 0, 0, 0, 0, 1, 32'h1000 + 32'(i));
            @(negedge clk);
            checkOutput("fetch_ack", 32'(prg_ack), 32'd1);
            checkOutput("fetch_wen", 32'(mem_wen), 32'd0);
            checkOutput("fetch_sel", 32'(mem_sel), 32'hF);
            checkOutput("fetch_gnt", 32'(gnt), 32'd1);
            checkOutput("fetch_adr", mem_adr, 32'(4 * i));
            checkOutput("fetch_rdt", prg_rdt, 32'h1000 + 32'(i));
            nextCycle();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        nextCycle();

        // Data priority when both request together.
        applyStimulus(1, 32'h40, 1, 1, 32'h100, 4'hF, 32'hDEADBEEF, 1, 32'h55);
        @(negedge clk);
        checkOutput("prio_adr", mem_adr, 32'h100);
        checkOutput("prio_wdt", mem_wdt, 32'hDEADBEEF);
        checkOutput("prio_wen", 32'(mem_wen), 32'd1);
        checkOutput("prio_dat_ack", 32'(dat_ack), 32'd1);
        checkOutput("prio_prg_ack", 32'(prg_ack), 32'd0);
        checkOutput("prio_gnt", 32'(gnt), 32'd2);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        nextCycle();

        // Lock on fetch with a delayed ack while data starts requesting.
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1, 32'h200, c >= 1, 0, 32'h300, 4'hF, 0, c == 3, 32'h77);
            @(negedge clk);
            checkOutput("lock_adr", mem_adr, 32'h200);
            checkOutput("lock_gnt", 32'(gnt), 32'd1);
            checkOutput("lock_prg_ack", 32'(prg_ack), 32'(c == 3));
            checkOutput("lock_dat_ack", 32'(dat_ack), 32'd0);
            nextCycle();
        end
        applyStimulus(0, 0, 1, 0, 32'h300, 4'hF, 0, 0, 32'h88);
        @(negedge clk);
        checkOutput("lock_next_gnt", 32'(gnt), 32'd2);
        checkOutput("lock_next_adr", mem_adr, 32'h300);
        nextCycle();
        applyStimulus(0, 0, 1, 0, 32'h300, 4'hF, 0, 1, 32'h99);
        @(negedge clk);
        checkOutput("lock_next_ack", 32'(dat_ack), 32'd1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        nextCycle();

        // Starvation: four data grants, then one fetch, then data again.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 32'h400, 1, 0, 32'h404, 4'hF, 0, 1, 32'(i));
            @(negedge clk);
            checkOutput("starve_dat_ack", 32'(dat_ack), 32'(i != 4));
            checkOutput("starve_prg_ack", 32'(prg_ack), 32'(i == 4));
            nextCycle();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        nextCycle();

        // Violation: locked data owner drops req; a stray ack is ignored.
        applyStimulus(0, 0, 1, 1, 32'h500, 4'h3, 32'h1234, 0, 0);
        @(negedge clk);
        checkOutput("viol_gnt", 32'(gnt), 32'd2);
        checkOutput("viol_req", 32'(mem_req), 32'd1);
        nextCycle();
        applyStimulus(0, 0, 0, 1, 32'h500, 4'h3, 32'h1234, 1, 0);
        @(negedge clk);
        checkOutput("viol_drop_req", 32'(mem_req), 32'd0);
        checkOutput("viol_drop_ack", 32'(dat_ack), 32'd0);
        nextCycle();
        applyStimulus(1, 32'h504, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("viol_idle_gnt", 32'(gnt), 32'd1);
        nextCycle();
        applyStimulus(1, 32'h504, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        checkOutput("viol_prg_ack", 32'(prg_ack), 32'd1);
        nextCycle();

        // Reset mid-transfer: build cnt=1, lock DAT, then reset.
        applyStimulus(1, 32'h600, 1, 0, 32'h604, 4'hF, 0, 1, 0);
        @(negedge clk);
        checkOutput("rmid_pre_ack", 32'(dat_ack), 32'd1);
        nextCycle();
        applyStimulus(0, 0, 1, 1, 32'h608, 4'hF, 32'hCAFE, 0, 0);
        @(negedge clk);
        checkOutput("rmid_lock_gnt", 32'(gnt), 32'd2);
        nextCycle();
        rst = 1'b1;
        applyStimulus(0, 0, 1, 1, 32'h608, 4'hF, 32'hCAFE, 1, 0);
        @(negedge clk);
        checkOutput("rmid_req", 32'(mem_req), 32'd0);
        checkOutput("rmid_gnt", 32'(gnt), 32'd0);
        checkOutput("rmid_ack", 32'(dat_ack), 32'd0);
        nextCycle();
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("rpost_gnt", 32'(gnt), 32'd0);
        checkOutput("rpost_req", 32'(mem_req), 32'd0);
        nextCycle();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 32'h700, 1, 0, 32'h704, 4'hF, 0, 1, 0);
            @(negedge clk);
            checkOutput("rpost_dat_ack", 32'(dat_ack), 32'(i != 4));
            checkOutput("rpost_prg_ack", 32'(prg_ack), 32'(i == 4));
            nextCycle();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        nextCycle();
        nextCycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rp_bus_arb.md
Name: rp_bus_arb

Overview:
- Shares one unified memory port between the core's program (instruction fetch) bus and data (load/store) bus.
- Sits between the core and a single-port memory or interconnect.
- Uses the same req/ack protocol on all three ports: a transfer completes in the cycle where req and ack are both high; read data is valid in the ack cycle.
- Data has priority over fetch, with an anti-starvation counter; grant is held (locked) for multi-cycle transfers.

Parameters:
- AW, 32, address width (program and data sides share it).
- DW, 32, data width.
- SW, DW/8, byte select width.
- MAXW, 4, max consecutive data grants while a fetch waits; 0 means the program always wins when both request.
- CW, $clog2(MAXW+1), starvation counter width (derived).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- prg_req  in  1  fetch request
- prg_adr  in  AW  fetch address
- prg_rdt  out  DW  fetch read data
- prg_ack  out  1  fetch acknowledge
- dat_req  in  1  load/store request
- dat_wen  in  1  write enable
- dat_adr  in  AW  data address
- dat_sel  in  SW  byte select
- dat_wdt  in  DW  write data
- dat_rdt  out  DW  load read data
- dat_ack  out  1  data acknowledge
- mem_req  out  1  memory request
- mem_wen  out  1  memory write enable
- mem_adr  out  AW  memory address
- mem_sel  out  SW  memory byte select
- mem_wdt  out  DW  memory write data
- mem_rdt  in  DW  memory read data
- mem_ack  in  1  memory acknowledge
- gnt  out  2  current owner, one-hot: [0]=prg, [1]=dat, 00 = none

Behaviour:
- Reset:
  - state=IDLE, cnt=0.
  - While rst is high, mem_req, prg_ack, dat_ack are 0 and gnt is 00.
  - rst mid-transfer abandons it; no ack is forwarded.
- States: IDLE, PRG (locked to fetch), DAT (locked to data).
- Winner in IDLE (combinational, same cycle):
  - Only one req high: that requester wins.
  - Both high and cnt<MAXW: DAT wins.
  - Both high and cnt==MAXW: PRG wins.
  - None high: no owner, mem_req=0.
- Zero-latency grant: in IDLE the winner drives mem_* in the same cycle. No bubble between back-to-back transfers.
- Mux, when owner=PRG:
  - mem_adr=prg_adr, mem_wen=0, mem_sel='1, mem_wdt='0.
- Mux, when owner=DAT:
  - dat_* are passed through to mem_*.
- Mux, no owner:
  - mem_* = 0.
- Ack and read data:
  - mem_ack is routed only to the owner's ack. The other ack stays 0.
  - prg_rdt and dat_rdt both = mem_rdt (unconditional fan-out); valid only with the respective ack.
- Transitions:
  - IDLE, winner present, mem_ack=0: go to the winner's locked state.
  - IDLE, winner present, mem_ack=1: stay IDLE (single-cycle transfer).
  - PRG/DAT, mem_ack=1: go to IDLE.
  - PRG/DAT: ignore the other requester until that ack.
- Requesters must hold req and payload stable until ack.
  - Owner drops req while locked (protocol violation): mem_req=0 that cycle, return to IDLE next cycle, no ack forwarded.
- Starvation counter cnt:
  - Increments (saturating at MAXW) on each completed DAT transfer whose ack cycle sees prg_req=1.
  - Clears to 0 on a completed PRG transfer, or on any completed transfer with prg_req=0.
- gnt reflects the combinational owner (IDLE winner or locked state).
- A memory ack while mem_req=0 is ignored.

Test Plan:
- Fetch only: prg_req=1 continuously, mem_ack=1 every cycle, adr 0x0,0x4,0x8 -> prg_ack every cycle, mem_wen=0, mem_sel=4'hF, no bubbles, gnt=01.
- Data priority: both req in the same cycle, cnt=0, dat_adr=0x100, dat_wen=1, dat_wdt=0xDEADBEEF -> mem_adr=0x100, mem_wdt=0xDEADBEEF, dat_ack with mem_ack, prg_ack=0.
- Lock: PRG granted, mem_ack delayed 3 cycles, dat_req rises in cycle 1 -> mem_adr stays prg_adr for 4 cycles, state PRG, then DAT is served the cycle after the ack.
- Starvation, MAXW=4: both req held, single-cycle acks -> 4 data acks, then 1 prg ack, then cnt=0 and data resumes.
- Violation: DAT locked and dat_req dropped before ack -> mem_req=0 that cycle, IDLE next cycle, no dat_ack.
- Reset mid-transfer: rst asserted in the DAT state with mem_ack pending -> mem_req=0, gnt=00 immediately; after release, state=IDLE and cnt=0.
